// File: rtl/fetch_unit_bp_pkg.sv
// fetch_unit_bp_pkg: shared opcodes, fetch FSM states and immediate decoders
package fetch_unit_bp_pkg;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL = 7'b1101111;
  localparam logic [6:0] OPC_JALR = 7'b1100111;
  typedef enum logic [1:0] {FETCH_IDLE, FETCH_WAIT, FETCH_DROP} fetch_state_e;
  function automatic logic [31:0] imm_b(input logic [31:0] i);
    return {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
  endfunction
  function automatic logic [31:0] imm_j(input logic [31:0] i);
    return {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
  endfunction
endpackage

// File: rtl/fetch_unit_bp_bht.sv
// fetch_bht: 2-bit saturating branch history table, combinational lookup, commit-time training
module fetch_bht #(
  parameter int IDX_BITS = 6
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                rdy_in,
  input  logic [IDX_BITS-1:0] lookup_idx,
  output logic                lookup_taken,
  input  logic                commit,
  input  logic [IDX_BITS-1:0] commit_idx,
  input  logic                commit_taken
);
  logic [1:0] ctr [2**IDX_BITS];
  logic [1:0] cur;
  assign cur = ctr[commit_idx];
  // lookup reads the pre-update value when it collides with a commit
  assign lookup_taken = ctr[lookup_idx][1];
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in)
      for (int k = 0; k < 2**IDX_BITS; k++) ctr[k] <= 2'b01;
    else if (rdy_in && commit)
      ctr[commit_idx] <= commit_taken ? (cur == 2'b11 ? cur : cur + 2'd1)
                                      : (cur == 2'b00 ? cur : cur - 2'd1);
endmodule

// File: rtl/fetch_unit_bp.sv
// fetch_unit_bp: PC + single-outstanding fetch FSM + instruction queue + optional BHT prediction
module fetch_unit_bp
  import fetch_unit_bp_pkg::*;
#(
  parameter int          ISQ_DEPTH      = 16,
  parameter int          BHT_INDEX_BITS = 6,
  parameter int          PREDICT_MODE   = 1,
  parameter logic [31:0] RESET_PC       = 32'h0
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        is_idle,
  output logic        fetch_start,
  output logic [31:0] pc_out,
  input  logic        finish_fetch,
  input  logic [31:0] instruction_in,
  input  logic [31:0] instruction_pc_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instruction,
  output logic [31:0] out_pc,
  output logic        out_predict,
  input  logic        rob_commit_branch,
  input  logic [31:0] rob_pc_commit,
  input  logic        rob_taken,
  input  logic        roll_back_in,
  input  logic [31:0] rob_pc_result
);
  localparam int PW = $clog2(ISQ_DEPTH);
  localparam logic [PW:0] FULL = ISQ_DEPTH[PW:0];
  fetch_state_e state, state_n;
  logic [31:0] pc, pc_n;
  logic [31:0] q_ins [ISQ_DEPTH];
  logic [31:0] q_pc [ISQ_DEPTH];
  logic [ISQ_DEPTH-1:0] q_pred;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [PW:0] count;
  logic [6:0] opc;
  logic issue, push, pop, bp_taken, pred;
  logic unused_rob;
  assign unused_rob = ^{rob_pc_commit, rob_taken, rob_commit_branch};
  generate
    if (PREDICT_MODE == 1) begin : g_bht
      fetch_bht #(.IDX_BITS(BHT_INDEX_BITS)) u_bht (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .rdy_in      (rdy_in),
        .lookup_idx  (instruction_pc_in[BHT_INDEX_BITS+1:2]),
        .lookup_taken(bp_taken),
        .commit      (rob_commit_branch),
        .commit_idx  (rob_pc_commit[BHT_INDEX_BITS+1:2]),
        .commit_taken(rob_taken)
      );
    end else begin : g_static
      assign bp_taken = 1'b0;
    end
  endgenerate
  assign out_valid = count != '0;
  assign out_instruction = out_valid ? q_ins[rd_ptr] : '0;
  assign out_pc = out_valid ? q_pc[rd_ptr] : '0;
  assign out_predict = out_valid && q_pred[rd_ptr];
  assign issue = rdy_in && state == FETCH_IDLE && is_idle && count < FULL && !roll_back_in;
  assign push = rdy_in && state == FETCH_WAIT && finish_fetch && !roll_back_in;
  assign pop = rdy_in && out_valid && out_ready && !roll_back_in;
  always_comb begin
    opc = instruction_in[6:0];
    pred = opc == OPC_JAL || (opc == OPC_BRANCH && bp_taken);
    pc_n = roll_back_in ? rob_pc_result
         : !push ? pc
         : opc == OPC_JAL ? pc + imm_j(instruction_in)
         : pred ? pc + imm_b(instruction_in)
         : pc + 32'd4;
    state_n = state;
    case (state)
      FETCH_IDLE: state_n = issue ? FETCH_WAIT : FETCH_IDLE;
      FETCH_WAIT: state_n = finish_fetch ? FETCH_IDLE : roll_back_in ? FETCH_DROP : FETCH_WAIT;
      FETCH_DROP: state_n = finish_fetch ? FETCH_IDLE : FETCH_DROP;
      default:    state_n = FETCH_IDLE;
    endcase
  end
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) begin
      state <= FETCH_IDLE;
      pc <= RESET_PC;
      pc_out <= RESET_PC;
      fetch_start <= 1'b0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else if (rdy_in) begin
      state <= state_n;
      pc <= pc_n;
      fetch_start <= issue;
      if (issue) pc_out <= pc;
      if (roll_back_in) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop) rd_ptr <= rd_ptr + PW'(1);
        if (push != pop) count <= push ? count + (PW+1)'(1) : count - (PW+1)'(1);
      end
    end else begin
      fetch_start <= 1'b0;
    end
  always_ff @(posedge clk_in)
    if (push) begin
      q_ins[wr_ptr] <= instruction_in;
      q_pc[wr_ptr] <= instruction_pc_in;
      q_pred[wr_ptr] <= pred;
    end
endmodule

// File: tb/tb_fetch_unit_bp.sv
// tb_fetch_unit_bp: directed vector table plus hand sequences for BHT, full queue, rollback, stall, reset
module tb_fetch_unit_bp;
  localparam logic [31:0] NOP = 32'h00000013;
  localparam logic [31:0] BEQ8 = 32'h00000463;
  localparam logic [31:0] JAL16 = 32'h0100006f;
  logic clk = 0, rst = 1, rdy = 1, is_idle = 1, finish_fetch = 0, out_ready = 0;
  logic rob_commit_branch = 0, rob_taken = 0, roll_back = 0;
  logic [31:0] instr = 0, ipc = 0, rob_pc_commit = 0, rob_pc_result = 0;
  logic fetch_start, out_valid, out_predict;
  logic [31:0] pc_out, out_instruction, out_pc;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  fetch_unit_bp #(.ISQ_DEPTH(4), .BHT_INDEX_BITS(6), .PREDICT_MODE(1), .RESET_PC(32'h0)) dut (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .is_idle(is_idle),
    .fetch_start(fetch_start), .pc_out(pc_out), .finish_fetch(finish_fetch),
    .instruction_in(instr), .instruction_pc_in(ipc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instruction(out_instruction),
    .out_pc(out_pc), .out_predict(out_predict),
    .rob_commit_branch(rob_commit_branch), .rob_pc_commit(rob_pc_commit), .rob_taken(rob_taken),
    .roll_back_in(roll_back), .rob_pc_result(rob_pc_result)
  );
  typedef struct {
    logic [31:0] ins;
    logic [31:0] pc;
    logic        pred;
  } vec_t;
  vec_t v [8];
  logic [31:0] sb [$];
  logic [31:0] a;
  int n;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic wait_fetch(output logic [31:0] addr);
    int k = 0;
    while (fetch_start !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (fetch_start !== 1'b1) begin
      errors++;
      $display("FAIL fetch_timeout: got no fetch_start expected one within 20 cycles");
    end
    addr = pc_out;
  endtask
  task automatic respond(input logic [31:0] ins, input logic [31:0] addr);
    finish_fetch = 1;
    instr = ins;
    ipc = addr;
    @(negedge clk);
    finish_fetch = 0;
  endtask
  task automatic pop_one();
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    v[0] = '{NOP, 32'h00, 1'b0};
    v[1] = '{NOP, 32'h04, 1'b0};
    v[2] = '{NOP, 32'h08, 1'b0};
    v[3] = '{JAL16, 32'h0c, 1'b1};
    v[4] = '{32'h00008067, 32'h1c, 1'b0};
    v[5] = '{BEQ8, 32'h20, 1'b0};
    v[6] = '{32'hff9ff06f, 32'h24, 1'b1};
    v[7] = '{NOP, 32'h1c, 1'b0};
    @(negedge clk);
    check("rst_fetch_start", fetch_start, 0);
    check("rst_pc_out", pc_out, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_instruction", out_instruction, 0);
    check("rst_out_pc", out_pc, 0);
    check("rst_out_predict", out_predict, 0);
    rst = 0;
    for (int i = 0; i < 8; i++) begin
      wait_fetch(a);
      check("vec_pc_out", a, v[i].pc);
      respond(v[i].ins, a);
      check("vec_valid", out_valid, 1);
      check("vec_out_pc", out_pc, v[i].pc);
      check("vec_out_instruction", out_instruction, v[i].ins);
      check("vec_out_predict", out_predict, v[i].pred);
      pop_one();
    end
    wait_fetch(a);
    check("bht_pc", a, 32'h20);
    rob_commit_branch = 1; rob_pc_commit = 32'h20; rob_taken = 1;
    repeat (2) @(negedge clk);
    rob_commit_branch = 0;
    respond(BEQ8, a);
    check("bht_taken_predict", out_predict, 1);
    pop_one();
    wait_fetch(a);
    check("bht_taken_target", a, 32'h28);
    rob_commit_branch = 1; rob_taken = 0;
    repeat (3) @(negedge clk);
    rob_commit_branch = 0;
    respond(NOP, a);
    pop_one();
    wait_fetch(a);
    check("bht_seq_pc", a, 32'h2c);
    roll_back = 1; rob_pc_result = 32'h20;
    @(negedge clk);
    roll_back = 0;
    respond(NOP, a);
    check("bht_drop_valid", out_valid, 0);
    wait_fetch(a);
    check("bht_refetch", a, 32'h20);
    respond(BEQ8, a);
    check("bht_nt_predict", out_predict, 0);
    pop_one();
    wait_fetch(a);
    check("bht_nt_target", a, 32'h24);
    respond(NOP, a);
    pop_one();
    for (int i = 0; i < 4; i++) begin
      wait_fetch(a);
      respond(NOP, a);
      sb.push_back(a);
    end
    n = 0;
    repeat (10) begin
      @(negedge clk);
      if (fetch_start) n++;
    end
    check("full_no_fetch", n, 0);
    check("full_valid", out_valid, 1);
    for (int i = 0; i < 10; i++) begin
      check("wrap_order", out_pc, sb.pop_front());
      pop_one();
      wait_fetch(a);
      respond(NOP, a);
      sb.push_back(a);
    end
    for (int i = 0; i < 2; i++) begin
      check("drain_order", out_pc, sb.pop_front());
      pop_one();
    end
    wait_fetch(a);
    roll_back = 1; rob_pc_result = 32'h100;
    @(negedge clk);
    roll_back = 0;
    check("rb_flush_valid", out_valid, 0);
    check("rb_flush_pc", out_pc, 0);
    check("rb_flush_ins", out_instruction, 0);
    check("rb_no_fetch", fetch_start, 0);
    @(negedge clk);
    check("rb_drop_no_fetch", fetch_start, 0);
    respond(JAL16, a);
    check("rb_dropped", out_valid, 0);
    wait_fetch(a);
    check("rb_redirect", a, 32'h100);
    finish_fetch = 1; instr = JAL16; ipc = a;
    roll_back = 1; rob_pc_result = 32'h200;
    @(negedge clk);
    finish_fetch = 0; roll_back = 0;
    check("rbc_dropped", out_valid, 0);
    wait_fetch(a);
    check("rbc_redirect", a, 32'h200);
    respond(NOP, a);
    wait_fetch(a);
    check("stall_pc", a, 32'h204);
    rdy = 0; out_ready = 1;
    repeat (5) begin
      @(negedge clk);
      check("stall_fetch_start", fetch_start, 0);
      check("stall_valid", out_valid, 1);
      check("stall_out_pc", out_pc, 32'h200);
    end
    rdy = 1; out_ready = 0;
    @(negedge clk);
    check("stall_kept", out_pc, 32'h200);
    #2 rst = 1;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_pc_out", pc_out, 0);
    check("arst_fetch_start", fetch_start, 0);
    check("arst_out_pc", out_pc, 0);
    @(negedge clk);
    rst = 0;
    wait_fetch(a);
    check("arst_refetch", a, 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
